// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffered entry
// layout and the default reset PC.
package riscv_fetch_pkg;

   typedef enum logic {
      FETCH_RUN   = 1'b0,
      FETCH_FAULT = 1'b1
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Redirect targets are forced onto a word boundary before they become the PC.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Handshake bundle between the fetch stage, instruction memory, execute
// redirects and the decoder. The fetch stage is the master side.
interface riscv_fetch_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// Synchronous instruction buffer of {pc, inst} entries with push, pop and
// flush; a pushed entry becomes visible at the head on the following cycle.
module riscv_fetch_fifo
   import riscv_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               push_data,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   // A pop in the same cycle frees the slot, so a full buffer can still accept.
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests,
// buffers in-order responses and drops stale ones after an execute redirect.
module riscv_fetch
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic          clk,
   input  logic          rst,
   riscv_fetch_if.master bus,
   output logic          fetch_fault_o
);

   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);

   fetch_state_e   state;
   logic [31:0]    pc;
   logic [CW-1:0]  live_cnt;
   logic [CW-1:0]  drop_cnt;
   logic [CW-1:0]  drop_on_redirect;
   logic           req_fire;
   logic           rsp_live;
   logic           rsp_drop;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [FCW-1:0] fifo_count;
   fetch_entry_t   push_entry;
   fetch_entry_t   head_entry;

   assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_drop  = bus.imem_rsp_valid && (drop_cnt != '0);
   assign rsp_live  = bus.imem_rsp_valid && (drop_cnt == '0) && (live_cnt != '0);
   assign fifo_push = rsp_live && !bus.redirect_valid;
   assign fifo_pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

   // The oldest live request was issued live_cnt words behind the current PC.
   assign push_entry = '{pc: pc - (32'(live_cnt) << 2), inst: bus.imem_rsp_data};

   // Everything still owed by memory becomes stale; a response landing now is already paid for.
   assign drop_on_redirect = drop_cnt + live_cnt
                           - CW'(bus.imem_rsp_valid && ((drop_cnt != '0) || (live_cnt != '0)));

   // Credits: every live request owns a buffer slot, and dropped ones still occupy memory.
   always_comb begin
      bus.imem_req_valid = (state == FETCH_RUN) && !rst && !bus.redirect_valid
                        && ((int'(live_cnt) + int'(fifo_count)) < FIFO_DEPTH)
                        && ((int'(live_cnt) + int'(drop_cnt)) < MAX_OUTSTANDING);
   end

   assign bus.imem_req_addr = pc;
   assign bus.inst_valid    = !fifo_empty;
   assign bus.inst          = fifo_empty ? 32'h0 : head_entry.inst;
   assign bus.inst_pc       = fifo_empty ? 32'h0 : head_entry.pc;
   assign fetch_fault_o     = (state == FETCH_FAULT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH_RUN;
         pc       <= RESET_PC;
         live_cnt <= '0;
         drop_cnt <= '0;
      end else if (bus.redirect_valid) begin
         state    <= (bus.redirect_pc[1:0] != 2'b00) ? FETCH_FAULT : FETCH_RUN;
         pc       <= align_word(bus.redirect_pc);
         live_cnt <= '0;
         drop_cnt <= drop_on_redirect;
      end else begin
         if (req_fire) begin
            pc <= pc + 32'd4;
         end
         live_cnt <= live_cnt + CW'(req_fire) - CW'(rsp_live);
         drop_cnt <= drop_cnt - CW'(rsp_drop);
      end
   end

   riscv_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .flush     (bus.redirect_valid),
      .push_data (push_entry),
      .head      (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
      bus.imem_rsp_valid |-> ((live_cnt != '0) || (drop_cnt != '0)));

   fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      fifo_push |-> (!fifo_full || fifo_pop));

endmodule
